// File: rtl/alu_result_buffer_pkg.sv
// Shared definitions for the ALU result buffer: flag bit positions, the flags
// type and the occupancy states.
package alu_result_buffer_pkg;

  localparam int FLG_S   = 0;
  localparam int FLG_Z   = 1;
  localparam int FLG_CY  = 2;
  localparam int FLG_P   = 3;
  localparam int FLG_V   = 4;
  localparam int FLAGS_W = 5;

  typedef logic [FLAGS_W-1:0] flags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_fifo_mem.sv
// Register-array storage for the result FIFO: one write port and one
// combinational read port. Entries are not reset.
module alu_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 21
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Valid/ready FIFO for ALU results with sticky flag accumulation and a
// saturating accepted-result counter.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             z,
  input  flags_t                   flags_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_z,
  output flags_t                   out_flags,
  output flags_t                   sticky_flags,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              accepted
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  occ_state_e        occ_state_reg, occ_state_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]     level_reg, level_next;
  flags_t            sticky_reg, sticky_next;
  logic [15:0]       accepted_reg, accepted_next;
  logic              push, pop;
  logic [W+FLAGS_W-1:0] rd_entry;

  // Ready is decided from the registered state only, so a full buffer never
  // accepts in the same cycle it pops.
  assign in_ready  = (occ_state_reg != OCC_FULL);
  assign out_valid = (occ_state_reg != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (W + FLAGS_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && rst_n),
    .waddr (wr_ptr_reg),
    .wdata ({flags_in, z}),
    .raddr (rd_ptr_reg),
    .rdata (rd_entry)
  );

  assign out_z        = rd_entry[W-1:0];
  assign out_flags    = rd_entry[W+FLAGS_W-1:W];
  assign sticky_flags = sticky_reg;
  assign level        = level_reg;
  assign accepted     = accepted_reg;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    sticky_next    = clr_sticky ? '0 : sticky_reg;
    accepted_next  = accepted_reg;
    occ_state_next = occ_state_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
      sticky_next = sticky_next | flags_in;
      if (accepted_reg != 16'hFFFF) begin
        accepted_next = accepted_reg + 16'd1;
      end
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    if (push && !pop) begin
      level_next = level_reg + LW'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LW'(1);
    end

    if (level_next == '0) begin
      occ_state_next = OCC_EMPTY;
    end else if (level_next == LVL_FULL) begin
      occ_state_next = OCC_FULL;
    end else begin
      occ_state_next = OCC_PARTIAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_state_reg <= OCC_EMPTY;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      sticky_reg    <= '0;
      accepted_reg  <= '0;
    end else begin
      occ_state_reg <= occ_state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      sticky_reg    <= sticky_next;
      accepted_reg  <= accepted_next;
    end
  end

endmodule
